sram_port_ctrl: RTL and testbench

Initiator-side controller that drives the 64x128 single-port SRAM macro: sram_wen active-low, sram_wmask active-low per bit, registered read data one cycle after issue, read data zero in the cycle after a write.
Accepts 64-bit requests with byte strobes over a valid/ready interface and returns one response per request over valid/ready.
After reset it optionally sweeps all 64 lines to zero, because the macro has no reset.
It sits between the cache/LSU data path and the SRAM macro.

---
 rtl/sram_port_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_port_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Request/response front end for the 64x128 single-port SRAM macro.
// Optionally zero-fills the array after reset, since the macro has no reset.
module sram_port_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [9:0]   req_addr,
  input  logic         req_wen,
  input  logic [63:0]  req_wdata,
  input  logic [7:0]   req_wstrb,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  resp_rdata,
  output logic         init_done,
  output logic [5:0]   sram_addr,
  output logic         sram_wen,
  output logic [127:0] sram_wmask,
  output logic [127:0] sram_wdata,
  input  logic [127:0] sram_rdata
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CAPT,
    RESP
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        wen_q;
  logic        half_q;
  logic        fire;
  logic [63:0] strb_bits;
  logic        unused_addr;

  // Byte offset within a half is meaningless to the macro.
  assign unused_addr = ^req_addr[2:0];

  assign req_ready = !reset &&
    ((state == IDLE) || ((state == RESP) && resp_ready));
  assign resp_valid = !reset && (state == RESP);
  assign fire = req_valid && req_ready;

  always_comb begin
    strb_bits = '0;
    for (int i = 0; i < 8; i++) begin
      strb_bits[i*8 +: 8] = {8{req_wstrb[i]}};
    end
  end

  always_comb begin
    sram_addr  = '0;
    sram_wen   = 1'b1;
    sram_wmask = '1;
    sram_wdata = '0;
    if (!reset) begin
      if (state == INIT) begin
        sram_addr  = cnt;
        sram_wen   = 1'b0;
        sram_wmask = '0;
      end else if (fire) begin
        sram_addr  = req_addr[9:4];
        sram_wdata = {req_wdata, req_wdata};
        if (req_wen) begin
          sram_wen = 1'b0;
          if (req_addr[3]) begin
            sram_wmask = {~strb_bits, {64{1'b1}}};
          end else begin
            sram_wmask = {{64{1'b1}}, ~strb_bits};
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? INIT : IDLE;
      cnt        <= '0;
      wen_q      <= 1'b0;
      half_q     <= 1'b0;
      resp_rdata <= '0;
      init_done  <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          init_done <= 1'b1;
          if (fire) begin
            wen_q  <= req_wen;
            half_q <= req_addr[3];
            state  <= CAPT;
          end
        end
        CAPT: begin
          if (wen_q) begin
            resp_rdata <= '0;
          end else if (half_q) begin
            resp_rdata <= sram_rdata[127:64];
          end else begin
            resp_rdata <= sram_rdata[63:0];
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            if (fire) begin
              wen_q  <= req_wen;
              half_q <= req_addr[3];
              state  <= CAPT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: macro model, byte-level reference memory,
// directed scenarios followed by randomized traffic.
module tb_sram_port_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [9:0]   req_addr;
  logic         req_wen;
  logic [63:0]  req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_rdata;
  logic         init_done;
  logic [5:0]   sram_addr;
  logic         sram_wen;
  logic [127:0] sram_wmask;
  logic [127:0] sram_wdata;
  logic [127:0] sram_rdata;

  int passed = 0;
  int total  = 0;

  logic [127:0] mem [0:63];
  logic [7:0]   ref_mem [0:1023];
  logic [63:0]  exp_q [$];

  always #5 clock = ~clock;

  sram_port_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_wen   (sram_wen),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Macro model: active-low bit mask, registered read, zero after a write.
  always @(posedge clock) begin
    if (!sram_wen) begin
      mem[sram_addr] <= (mem[sram_addr] & sram_wmask) |
                        (sram_wdata & ~sram_wmask);
      sram_rdata <= '0;
    end else begin
      sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_read(input logic [9:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*8 +: 8] = ref_mem[a[9:3] * 8 + i];
    end
    return r;
  endfunction

  task automatic ref_write(input logic [9:0] a, input logic [63:0] d,
                           input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) ref_mem[a[9:3] * 8 + i] = d[i*8 +: 8];
    end
  endtask

  function automatic logic [127:0] exp_mask(input logic w,
                                            input logic [9:0] a,
                                            input logic [7:0] s);
    logic [127:0] m;
    for (int j = 0; j < 128; j++) begin
      m[j] = !(w && ((j / 64) == int'(a[3])) && s[(j % 64) / 8]);
    end
    return m;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  // Entered just after a clock edge with reset already released.
  task automatic init_sweep();
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      chk($sformatf("init_drive_%0d", k),
          {sram_wen, sram_addr, req_ready, init_done, sram_wmask, sram_wdata},
          {1'b0, 6'(k), 1'b0, 1'b0, 128'h0, 128'h0});
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("init_done", init_done, 1'b1);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_wen", sram_wen, 1'b1);
    @(posedge clock); #1;
  endtask

  // Returns one cycle after the fire edge (the capture cycle).
  task automatic issue(input logic w, input logic [9:0] a,
                       input logic [63:0] d, input logic [7:0] s,
                       input bit hs);
    int n;
    req_valid = 1'b1;
    req_wen   = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) begin
      chk("fire_timeout", req_ready, 1'b1);
    end else begin
      if (hs) begin
        chk("hs_valid", resp_valid, 1'b1);
        chk("hs_rdata", resp_rdata,
            exp_q.size() > 0 ? exp_q.pop_front() : 64'hx);
      end
      chk("sram_addr", sram_addr, a[9:4]);
      chk("sram_wen", sram_wen, !w);
      chk("sram_wmask", sram_wmask, exp_mask(w, a, s));
      chk("sram_wdata", sram_wdata, {d, d});
      exp_q.push_back(w ? 64'h0 : ref_read(a));
      if (w) ref_write(a, d, s);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input bit release_it);
    logic [63:0] snap;
    @(negedge clock);
    chk("lat_capt", resp_valid, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("lat_resp", resp_valid, 1'b1);
    snap = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_data", resp_rdata, snap);
      chk("stall_ready", req_ready, 1'b0);
    end
    if (release_it) begin
      @(posedge clock); #1;
      resp_ready = 1'b1;
      @(negedge clock);
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_rdata", resp_rdata,
          exp_q.size() > 0 ? exp_q.pop_front() : 64'hx);
      @(posedge clock); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic xact(input logic w, input logic [9:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    issue(w, a, d, s, 1'b0);
    collect(0, 1'b1);
  endtask

  initial begin
    logic [9:0] ra;
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wen    = 1'b0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs",
        {req_ready, resp_valid, init_done, sram_wen, sram_addr},
        {1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_wmask", sram_wmask, {128{1'b1}});
    chk("rst_wdata", sram_wdata, 128'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    ref_clear();
    init_sweep();

    xact(1'b0, 10'h2A0, 64'h0, 8'h00);
    xact(1'b1, 10'h018, 64'h1122334455667788, 8'hFF);
    xact(1'b0, 10'h018, 64'h0, 8'h00);
    xact(1'b0, 10'h010, 64'h0, 8'h00);
    xact(1'b1, 10'h018, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    xact(1'b0, 10'h01F, 64'h0, 8'h00);
    xact(1'b1, 10'h018, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    xact(1'b0, 10'h018, 64'h0, 8'h00);

    // Stalled response, then a new request fires on the release cycle.
    issue(1'b0, 10'h018, 64'h0, 8'h00, 1'b0);
    collect(5, 1'b0);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    issue(1'b1, 10'h3F8, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
    resp_ready = 1'b0;
    collect(0, 1'b1);
    xact(1'b0, 10'h3F8, 64'h0, 8'h00);
    xact(1'b0, 10'h3F0, 64'h0, 8'h00);

    for (int t = 0; t < 60; t++) begin
      ra = {3'(t % 4 == 0 ? 7 : $urandom_range(0, 3)),
            3'($urandom), 1'($urandom), 3'($urandom)};
      issue(1'($urandom), ra, {$urandom, $urandom}, 8'($urandom), 1'b0);
      collect($urandom_range(0, 2), 1'b1);
    end

    // Reset while the capture cycle is in progress.
    issue(1'b0, 10'h3F8, 64'h0, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_capt_valid", resp_valid, 1'b0);
    chk("rst_capt_done", init_done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    ref_clear();
    init_sweep();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("no_stale_resp", resp_valid, 1'b0);
      @(posedge clock); #1;
    end
    xact(1'b0, 10'h3F8, 64'h0, 8'h00);
    xact(1'b0, 10'h018, 64'h0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
